rf_write_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 4 x 8-bit register file. It shares the single register-file write port (write enable, write select, input data) between two requesters, A (execute unit) and B (load unit), using round-robin arbitration. It also runs a 4-cycle clear-all sequence on request. It sits between the requesters and the register file; the register file read ports are not touched.

---
 rtl/rf_write_arbiter.sv | 112 +++++++++++
 tb/tb_rf_write_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port (A/B) plus a NUM_REGS-cycle clear-all sequencer.
// Latency: 1 cycle from sampled req to gnt/rf_write_*; backpressure: requesters hold req/sel/data until gnt, and wait through CLEAR.
module rf_write_arbiter #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic              clr_req,
  output logic              busy,
  output logic [7:0]        conflict_cnt,
  output logic              rf_write_en,
  output logic [SEL_W-1:0]  rf_write_sel,
  output logic [DATA_W-1:0] rf_input_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_t            state, state_n;
  logic [SEL_W-1:0]  clr_idx, clr_idx_n;
  logic              last, last_n;
  logic              a_gnt_n, b_gnt_n, busy_n, we_n;
  logic [SEL_W-1:0]  sel_n;
  logic [DATA_W-1:0] data_n;
  logic [7:0]        cnt_n;
  logic              a_el, b_el, win_a, win_b;

  // A request whose grant is showing this cycle has already been served.
  assign a_el  = a_req & ~a_gnt;
  assign b_el  = b_req & ~b_gnt;
  assign win_a = a_el & (~b_el | (last == LAST_B));
  assign win_b = b_el & ~win_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      clr_idx       <= '0;
      last          <= LAST_B;
      a_gnt         <= 1'b0;
      b_gnt         <= 1'b0;
      busy          <= 1'b0;
      conflict_cnt  <= 8'h00;
      rf_write_en   <= 1'b0;
      rf_write_sel  <= '0;
      rf_input_data <= '0;
    end else begin
      state         <= state_n;
      clr_idx       <= clr_idx_n;
      last          <= last_n;
      a_gnt         <= a_gnt_n;
      b_gnt         <= b_gnt_n;
      busy          <= busy_n;
      conflict_cnt  <= cnt_n;
      rf_write_en   <= we_n;
      rf_write_sel  <= sel_n;
      rf_input_data <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_idx_n = clr_idx;
    last_n    = last;
    a_gnt_n   = 1'b0;
    b_gnt_n   = 1'b0;
    busy_n    = 1'b0;
    we_n      = 1'b0;
    sel_n     = rf_write_sel;
    data_n    = rf_input_data;
    // Contention is tallied whenever both requesters are asking, independent of FSM state.
    cnt_n     = (a_req && b_req && conflict_cnt != 8'hFF) ? conflict_cnt + 8'd1 : conflict_cnt;

    if (state == IDLE && clr_req) begin
      state_n   = CLEAR;
      clr_idx_n = '0;
      busy_n    = 1'b1;
      we_n      = 1'b1;
      sel_n     = '0;
      data_n    = '0;
    end else if (state == CLEAR && clr_idx != SEL_W'(NUM_REGS - 1)) begin
      clr_idx_n = clr_idx + 1'b1;
      busy_n    = 1'b1;
      we_n      = 1'b1;
      sel_n     = clr_idx + 1'b1;
      data_n    = '0;
    end else begin
      // The edge ending the last clear write already arbitrates, so requests never lose a cycle.
      state_n = IDLE;
      a_gnt_n = win_a;
      b_gnt_n = win_b;
      if (win_a || win_b) begin
        we_n   = 1'b1;
        sel_n  = win_a ? a_sel : b_sel;
        data_n = win_a ? a_data : b_data;
        last_n = win_b;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: grants, alternation, single-requester rate, clear sequence, saturation, reset abort.
module tb_rf_write_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req, clr_req;
  logic [1:0] a_sel, b_sel;
  logic [7:0] a_data, b_data;
  logic       a_gnt, b_gnt, busy, rf_write_en;
  logic [7:0] conflict_cnt, rf_input_data;
  logic [1:0] rf_write_sel;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_sel(a_sel), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_sel(b_sel), .b_data(b_data), .b_gnt(b_gnt),
    .clr_req(clr_req), .busy(busy), .conflict_cnt(conflict_cnt),
    .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_input_data(rf_input_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, conflict_cnt, 8'h00);
    chk({tag, "_we"}, rf_write_en, 0);
    chk({tag, "_sel"}, rf_write_sel, 0);
    chk({tag, "_data"}, rf_input_data, 8'h00);
  endtask

  initial begin
    reset = 1'b0;
    a_req = 0; b_req = 0; clr_req = 0;
    a_sel = 0; b_sel = 0; a_data = 0; b_data = 0;
    #3;
    chk_reset_vals("rst");
    #9;
    reset = 1'b1;

    // Single A write
    a_req = 1; a_sel = 2; a_data = 8'h5A;
    tick();
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_b_gnt", b_gnt, 0);
    chk("t1_we", rf_write_en, 1);
    chk("t1_sel", rf_write_sel, 2);
    chk("t1_data", rf_input_data, 8'h5A);
    a_req = 0;
    tick();
    chk("t1_a_gnt_off", a_gnt, 0);
    chk("t1_we_off", rf_write_en, 0);
    chk("t1_sel_hold", rf_write_sel, 2);
    chk("t1_data_hold", rf_input_data, 8'h5A);

    // Both held: alternate A,B starting with A, every cycle a write, count every cycle
    do_reset();
    a_req = 1; a_sel = 1; a_data = 8'h11;
    b_req = 1; b_sel = 3; b_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
      chk("t2_b_gnt", b_gnt, (i % 2 == 1) ? 1 : 0);
      chk("t2_we", rf_write_en, 1);
      chk("t2_sel", rf_write_sel, (i % 2 == 0) ? 1 : 3);
      chk("t2_data", rf_input_data, (i % 2 == 0) ? 8'h11 : 8'h22);
      chk("t2_cnt", conflict_cnt, i + 1);
    end
    a_req = 0; b_req = 0;

    // Only B held for 6 cycles: grant every other cycle, no conflicts
    do_reset();
    b_req = 1; b_sel = 1; b_data = 8'h77;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_b_gnt", b_gnt, (i % 2 == 0) ? 1 : 0);
      chk("t3_we", rf_write_en, (i % 2 == 0) ? 1 : 0);
      chk("t3_cnt", conflict_cnt, 0);
    end
    b_req = 0;
    tick();

    // Clear sequence with A raised mid-sequence
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_busy", busy, 1);
      chk("t4_we", rf_write_en, 1);
      chk("t4_sel", rf_write_sel, i);
      chk("t4_data", rf_input_data, 8'h00);
      chk("t4_gnt", {a_gnt, b_gnt}, 2'b00);
      if (i == 1) begin
        a_req = 1; a_sel = 3; a_data = 8'hC3;
      end
      if (i == 2) clr_req = 1;
      if (i == 3) clr_req = 0;
      tick();
    end
    chk("t4_busy_fall", busy, 0);
    chk("t4_a_gnt", a_gnt, 1);
    chk("t4_sel_a", rf_write_sel, 3);
    chk("t4_data_a", rf_input_data, 8'hC3);
    a_req = 0;
    tick();
    chk("t4_idle_we", rf_write_en, 0);

    // Same-cycle A, B, clr: CLEAR wins, tie counted, A wins afterwards
    do_reset();
    a_req = 1; a_sel = 0; a_data = 8'hA0;
    b_req = 1; b_sel = 2; b_data = 8'hB0;
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("t5_busy", busy, 1);
    chk("t5_gnt", {a_gnt, b_gnt}, 2'b00);
    chk("t5_cnt", conflict_cnt, 1);
    tick(); tick(); tick();
    chk("t5_cnt4", conflict_cnt, 4);
    tick();
    chk("t5_busy_off", busy, 0);
    chk("t5_a_first", {a_gnt, b_gnt}, 2'b10);
    chk("t5_data", rf_input_data, 8'hA0);
    chk("t5_cnt5", conflict_cnt, 5);

    // Saturation over 300 cycles of contention
    do_reset();
    for (int i = 0; i < 254; i++) tick();
    chk("t6_cnt_fe", conflict_cnt, 8'hFE);
    tick();
    chk("t6_cnt_ff", conflict_cnt, 8'hFF);
    for (int i = 0; i < 45; i++) tick();
    chk("t6_cnt_sat", conflict_cnt, 8'hFF);
    a_req = 0; b_req = 0;
    tick();

    // Reset asserted in second CLEAR cycle
    clr_req = 1;
    tick();
    clr_req = 0;
    tick();
    chk("t7_busy", busy, 1);
    chk("t7_sel1", rf_write_sel, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t7_abort");
    #3;
    reset = 1'b1;
    a_req = 1; a_sel = 1; a_data = 8'h3C;
    b_req = 1; b_sel = 2; b_data = 8'h4D;
    tick();
    chk("t7_busy_idle", busy, 0);
    chk("t7_tie_a", {a_gnt, b_gnt}, 2'b10);
    chk("t7_data", rf_input_data, 8'h3C);
    a_req = 0; b_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
